// File: rtl/pool1_stream_if.sv
// LII physical stream link: AXI-Stream style data/valid/ready plus node ids.
interface pool1_stream_if #(
  parameter int PW = 64
);
  logic [PW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic [7:0]    src;
  logic [7:0]    dst;

  modport master (output tdata, output tvalid, output src, output dst, input tready);
  modport slave  (input tdata, input tvalid, input src, input dst, output tready);
endinterface

// File: rtl/pool1_stream_stage.sv
// 2x2 stride-2 signed max-pool over a raster pixel stream, one half-row line
// buffer and a single registered output slot.
module pool1_stream_stage #(
  parameter int         IMG_W   = 28,
  parameter int         IMG_H   = 28,
  parameter int         CH      = 6,
  parameter int         DW      = 8,
  parameter int         PW      = 64,
  parameter logic [7:0] MY_ID   = 8'h01,
  parameter logic [7:0] NEXT_ID = 8'h02
) (
  input  logic          aclk,
  input  logic          arstn,
  pool1_stream_if.slave  lii_in_p0,
  pool1_stream_if.master lii_out_p0,
  output logic          frame_done,
  output logic [15:0]   drop_cnt
);

  localparam int XW  = CH * DW;
  localparam int CW  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LBN = IMG_W / 2;
  localparam int LW  = (LBN > 1) ? $clog2(LBN) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [XW-1:0] pair;
  logic [XW-1:0] lb [LBN];
  logic [LW-1:0] lb_idx;
  logic [XW-1:0] lb_rd;
  logic [XW-1:0] in_data;
  logic [XW-1:0] pair_max;
  logic [XW-1:0] emit_data;
  logic [XW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          is_mine;
  logic          at_emit;
  logic          in_ready;
  logic          accept;
  logic          take;
  logic          drop;
  logic          out_fire;
  logic          last_col;
  logic          last_row;
  logic          unused_in;

  function automatic logic [XW-1:0] vmax(input logic [XW-1:0] a, input logic [XW-1:0] b);
    logic [XW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      r[k*DW +: DW] = ($signed(a[k*DW +: DW]) > $signed(b[k*DW +: DW])) ?
                      a[k*DW +: DW] : b[k*DW +: DW];
    end
    return r;
  endfunction

  always_comb begin
    in_data   = lii_in_p0.tdata[XW-1:0];
    lb_idx    = LW'(col >> 1);
    lb_rd     = lb[lb_idx];
    pair_max  = vmax(pair, in_data);
    emit_data = vmax(lb_rd, pair_max);
    last_col  = (col == CW'(IMG_W - 1));
    last_row  = (row == RW'(IMG_H - 1));
    is_mine   = (lii_in_p0.dst == MY_ID);
    at_emit   = col[0] & row[0];
    // Only a beat that would load the output slot can be stalled.
    in_ready  = !(is_mine && at_emit) || !out_valid || lii_out_p0.tready;
    accept    = lii_in_p0.tvalid & in_ready;
    take      = accept & is_mine;
    drop      = accept & ~is_mine;
    out_fire  = out_valid & lii_out_p0.tready;
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      col        <= '0;
      row        <= '0;
      pair       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      frame_done <= out_fire & out_last;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
      if (take) begin
        if (!col[0]) pair <= in_data;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (take && at_emit) begin
        out_valid <= 1'b1;
        out_data  <= emit_data;
        out_last  <= last_row & last_col;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (take && col[0] && !row[0]) lb[lb_idx] <= pair_max;
  end

  assign unused_in = ^{lii_in_p0.src, lii_in_p0.tdata};

  assign lii_in_p0.tready  = in_ready;
  assign lii_out_p0.tvalid = out_valid;
  assign lii_out_p0.tdata  = PW'(out_data);
  assign lii_out_p0.src    = MY_ID;
  assign lii_out_p0.dst    = NEXT_ID;

endmodule

// File: tb/tb_pool1_stream_stage.sv
// Randomised bench for pool1_stream_stage against a frame-array pooling model.
module tb_pool1_stream_stage;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int CH = 6;
  localparam int XW = 48;
  localparam logic [63:0] FIRST_PAT = 64'h0000_0706_0504_0302;
  localparam logic [63:0] LAST_PAT  = 64'h0000_3B3A_3938_3736;

  logic        aclk = 1'b0;
  logic        arstn = 1'b0;
  logic        frame_done;
  logic [15:0] drop_cnt;

  pool1_stream_if #(.PW(64)) in_if ();
  pool1_stream_if #(.PW(64)) out_if ();

  pool1_stream_stage #(
    .IMG_W(W), .IMG_H(H), .CH(CH), .DW(8), .PW(64), .MY_ID(8'h01), .NEXT_ID(8'h02)
  ) dut (
    .aclk(aclk), .arstn(arstn), .lii_in_p0(in_if), .lii_out_p0(out_if),
    .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XW-1:0] pmax(input logic [XW-1:0] a, input logic [XW-1:0] b);
    logic [XW-1:0] r;
    for (int k = 0; k < CH; k++) begin
      r[k*8 +: 8] = ($signed(a[k*8 +: 8]) > $signed(b[k*8 +: 8])) ? a[k*8 +: 8] : b[k*8 +: 8];
    end
    return r;
  endfunction

  typedef struct {
    logic [XW-1:0] d;
    bit            last;
  } exp_t;

  // reference model state
  logic [XW-1:0] fr [H][W];
  exp_t          q[$];
  int            mrow = 0;
  int            mcol = 0;
  logic [15:0]   drop_exp = '0;
  bit            exp_done = 0;
  bit            prev_stall = 0;
  bit            emit_prev = 0;
  logic [63:0]   prev_data = '0;
  logic [63:0]   last_emit = '0;
  int            n_out = 0;
  int            n_done = 0;
  logic [63:0]   out_log [600];
  int            rdy_mode = 1;

  always @(posedge aclk) begin
    #2;
    case (rdy_mode)
      0:       out_if.tready = 1'b0;
      2:       out_if.tready = 1'($urandom_range(0, 1));
      default: out_if.tready = 1'b1;
    endcase
  end

  always @(negedge aclk) begin
    exp_t e;
    bit   exp_ready;
    if (!arstn) begin
      check("reset_tvalid", {63'd0, out_if.tvalid}, 64'd0);
      mrow = 0; mcol = 0; q.delete(); drop_exp = '0;
      exp_done = 0; prev_stall = 0; emit_prev = 0;
    end else begin
      check("frame_done", {63'd0, frame_done}, {63'd0, exp_done});
      if (frame_done) n_done++;
      check("drop_cnt", {48'd0, drop_cnt}, {48'd0, drop_exp});
      if (emit_prev) begin
        check("latency_tvalid", {63'd0, out_if.tvalid}, 64'd1);
        check("latency_tdata", out_if.tdata, last_emit);
      end
      if (prev_stall) begin
        check("hold_tvalid", {63'd0, out_if.tvalid}, 64'd1);
        check("hold_tdata", out_if.tdata, prev_data);
      end
      exp_ready = !((mrow % 2 == 1) && (mcol % 2 == 1) && (in_if.dst == 8'h01)) ||
                  !out_if.tvalid || out_if.tready;
      check("in_tready", {63'd0, in_if.tready}, {63'd0, exp_ready});
      exp_done = 0;
      emit_prev = 0;
      prev_stall = out_if.tvalid && !out_if.tready;
      prev_data = out_if.tdata;
      if (out_if.tvalid && out_if.tready) begin
        check("out_pending", {63'd0, q.size() != 0}, 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("out_tdata", out_if.tdata, {16'h0, e.d});
          if (n_out < 600) out_log[n_out] = out_if.tdata;
          n_out++;
          exp_done = e.last;
        end
      end
      if (in_if.tvalid && in_if.tready) begin
        if (in_if.dst == 8'h01) begin
          fr[mrow][mcol] = in_if.tdata[XW-1:0];
          if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
            e.d = pmax(pmax(fr[mrow-1][mcol-1], fr[mrow-1][mcol]),
                       pmax(fr[mrow][mcol-1], fr[mrow][mcol]));
            e.last = (mrow == H - 1) && (mcol == W - 1);
            q.push_back(e);
            emit_prev = 1;
            last_emit = {16'h0, e.d};
          end
          mcol++;
          if (mcol == W) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
          end
        end else if (drop_exp != 16'hFFFF) begin
          drop_exp++;
        end
      end
    end
  end

  function automatic logic [63:0] pattern(input int mode, input int r, input int c);
    logic [63:0] d;
    logic [7:0]  b;
    int          v;
    d = '0;
    if (mode == 0) begin
      for (int k = 0; k < CH; k++) begin
        v = r + c + k;
        if (v > 127) v = 127;
        d[k*8 +: 8] = 8'(v);
      end
    end else if (mode == 1) begin
      b = 8'h00;
      if (r == 0 && c == 0) b = 8'h80;
      if (r == 0 && c == 1) b = 8'hFF;
      if (r == 1 && c == 0) b = 8'hFB;
      if (r == 1 && c == 1) b = 8'h80;
      if (r == 0 && c == 2) b = 8'h7F;
      for (int k = 0; k < CH; k++) d[k*8 +: 8] = b;
    end else begin
      d = {$urandom, $urandom};
    end
    return d;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] dst, output int stalls);
    bit done;
    in_if.tdata = d;
    in_if.dst = dst;
    in_if.tvalid = 1'b1;
    stalls = 0;
    done = 0;
    while (!done) begin
      @(negedge aclk);
      if (in_if.tready) begin
        done = 1;
      end else begin
        @(posedge aclk);
        #1;
        stalls++;
        if (stalls > 2000) begin
          check("beat_accept_timeout", 64'(stalls), 64'd0);
          $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
          $fatal(1, "input beat never accepted");
        end
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic send_frame(input int mode, input bit bad, input int start, input int stop,
                            output int stalls);
    int s;
    stalls = 0;
    for (int i = start; i < stop; i++) begin
      send_beat(pattern(mode, i / W, i % W), 8'h01, s);
      stalls += s;
      if (bad && (i % 4 == 3)) begin
        send_beat({$urandom, $urandom}, 8'h07, s);
        stalls += s;
      end
    end
  endtask

  task automatic idle(input int n);
    in_if.tvalid = 1'b0;
    in_if.dst = 8'h01;
    rdy_mode = 1;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time exhausted");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    in_if.tvalid = 1'b0;
    in_if.tdata = '0;
    in_if.src = 8'h00;
    in_if.dst = 8'h01;
    out_if.tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", {63'd0, out_if.tvalid}, 64'd0);
    check("rst_tdata", out_if.tdata, 64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    check("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    check("rst_src", {56'd0, out_if.src}, 64'h01);
    check("rst_dst", {56'd0, out_if.dst}, 64'h02);
    arstn = 1'b1;
    @(posedge aclk);
    #1;

    // ramp frame, full throughput
    n_out = 0; n_done = 0; rdy_mode = 1;
    send_frame(0, 0, 0, W * H, st);
    idle(8);
    check("t1_stalls", 64'(st), 64'd0);
    check("t1_outputs", 64'(n_out), 64'd196);
    check("t1_done", 64'(n_done), 64'd1);
    check("t1_first", out_log[0], FIRST_PAT);
    check("t1_last", out_log[195], LAST_PAT);

    // signed compare windows
    n_out = 0; n_done = 0;
    send_frame(1, 0, 0, W * H, st);
    idle(8);
    check("t2_neg_window", out_log[0], 64'h0000_FFFF_FFFF_FFFF);
    check("t2_pos_window", out_log[1], 64'h0000_7F7F_7F7F_7F7F);
    check("t2_outputs", 64'(n_out), 64'd196);

    // random data, random downstream ready, back-to-back frames
    n_out = 0; n_done = 0; rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin
      send_frame(2, 0, 0, W * H, st);
    end
    idle(20);
    check("t3_outputs", 64'(n_out), 64'd588);
    check("t3_done", 64'(n_done), 64'd3);

    // foreign-destination beats interleaved
    n_out = 0; n_done = 0; rdy_mode = 1;
    send_frame(0, 1, 0, W * H, st);
    idle(8);
    check("t4_drop_cnt", {48'd0, drop_cnt}, 64'd196);
    check("t4_outputs", 64'(n_out), 64'd196);
    check("t4_first", out_log[0], FIRST_PAT);
    check("t4_last", out_log[195], LAST_PAT);

    // backpressure: only the second emit beat stalls
    n_out = 0; n_done = 0; rdy_mode = 0;
    @(posedge aclk);
    #1;
    send_frame(0, 0, 0, W + 3, st);
    check("t5_no_stall_before", 64'(st), 64'd0);
    in_if.tdata = pattern(0, 1, 3);
    in_if.dst = 8'h01;
    in_if.tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("t5_tready_low", {63'd0, in_if.tready}, 64'd0);
      check("t5_tvalid_held", {63'd0, out_if.tvalid}, 64'd1);
      check("t5_tdata_held", out_if.tdata, FIRST_PAT);
      @(posedge aclk);
      #1;
    end
    rdy_mode = 1;
    send_frame(0, 0, W + 3, W * H, st);
    idle(8);
    check("t5_outputs", 64'(n_out), 64'd196);
    check("t5_done", 64'(n_done), 64'd1);

    // reset in mid-frame, then a clean frame
    rdy_mode = 2;
    send_frame(2, 0, 0, 9 * W + 13, st);
    arstn = 1'b0;
    in_if.tvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("t6_rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    check("t6_rst_tvalid", {63'd0, out_if.tvalid}, 64'd0);
    arstn = 1'b1;
    @(posedge aclk);
    #1;
    n_out = 0; n_done = 0;
    send_frame(0, 0, 0, W * H, st);
    idle(20);
    check("t6_outputs", 64'(n_out), 64'd196);
    check("t6_done", 64'(n_done), 64'd1);
    check("t6_first", out_log[0], FIRST_PAT);
    check("t6_last", out_log[195], LAST_PAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
